// File: rtl/sram_master_if.sv
// Client request/response and SRAM pin bundle for sram_master.
// The master modport is the controller's view; slave is the client + SRAM side.
interface sram_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  busy;
    logic                  sram_we;
    logic                  sram_oe;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_data, busy,
               sram_we, sram_oe, sram_addr, sram_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_data, busy,
               sram_we, sram_oe, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_master.sv
// Single-outstanding-request initiator for a synchronous single-port SRAM.
// Define SRAM_MASTER_CLEAR_EN to zero-fill the whole SRAM after every reset.
module sram_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_master_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        CAP   = 3'd3,
        RSP   = 3'd4,
        CLEAR = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Output registers are loaded from next-state values so each pin
    // toggles on the same edge that enters the corresponding state.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d = WR;
                        we_d    = 1'b1;
                        wdata_d = bus.req_wdata;
                    end else begin
                        state_d = RD;
                        oe_d    = 1'b1;
                    end
                end
            end
            WR:  state_d = IDLE;
            RD:  state_d = CAP;
            CAP: begin
                rsp_data_d  = bus.sram_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            CLEAR: begin
                if (addr_q == '1) begin
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SRAM_MASTER_CLEAR_EN
            state_q <= CLEAR;
            we_q    <= 1'b1;
`else
            state_q <= IDLE;
            we_q    <= 1'b0;
`endif
            oe_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.sram_we    = we_q;
    assign bus.sram_oe    = oe_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_sram_master.sv
// Self-checking bench for sram_master: directed scenarios plus random traffic
// against a word-array reference memory and a behavioural synchronous SRAM.
module tb_sram_master;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] sram_mem [16];
    logic [7:0] ref_mem  [16];
    bit         ref_ok   [16];

    sram_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    sram_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM: write on we, registered read data the cycle after oe.
    always @(posedge clk) begin
        if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_oe) bus.sram_rdata <= sram_mem[bus.sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) check("we_oe_overlap", bus.sram_we & bus.sram_oe, 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_timeout", bus.req_ready, 1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 4'($urandom);
        bus.req_wdata = 8'($urandom);
        check("wr_we", bus.sram_we, 1);
        check("wr_oe", bus.sram_oe, 0);
        check("wr_addr", bus.sram_addr, a);
        check("wr_wdata", bus.sram_wdata, d);
        check("wr_busy", bus.busy, 1);
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
        tick();
        check("wr_we_pulse", bus.sram_we, 0);
        check("wr_ready_after", bus.req_ready, 1);
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        logic [7:0] exp = ref_mem[a];
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = 8'($urandom);
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'($urandom);
        bus.rsp_ready = 1'($urandom);
        check("rd_oe", bus.sram_oe, 1);
        check("rd_we", bus.sram_we, 0);
        check("rd_addr", bus.sram_addr, a);
        check("rd_ready_busy", bus.req_ready, 0);
        tick();
        bus.rsp_ready = 1'($urandom);
        check("rd_oe_pulse", bus.sram_oe, 0);
        check("rd_rsp_early", bus.rsp_valid, 0);
        tick();
        bus.rsp_ready = 1'b0;
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_data", bus.rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rd_hold_valid", bus.rsp_valid, 1);
            check("rd_hold_data", bus.rsp_data, exp);
            check("rd_hold_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rd_rsp_drop", bus.rsp_valid, 0);
        check("rd_idle_ready", bus.req_ready, 1);
    endtask

    task automatic clear_check();
        for (int i = 0; i < 16; i++) begin
            check("clr_we", bus.sram_we, 1);
            check("clr_addr", bus.sram_addr, i);
            check("clr_wdata", bus.sram_wdata, 0);
            check("clr_ready", bus.req_ready, 0);
            tick();
        end
        check("clr_done_ready", bus.req_ready, 1);
        check("clr_done_we", bus.sram_we, 0);
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            ref_ok[i]  = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = 8'h00;
            ref_ok[i]   = 1'b0;
        end
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_oe", bus.sram_oe, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
`ifdef SRAM_MASTER_CLEAR_EN
        check("rst_busy", bus.busy, 1);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_we", bus.sram_we, 1);
`else
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_we", bus.sram_we, 0);
`endif
        #21 rst_n = 1'b1;
`ifdef SRAM_MASTER_CLEAR_EN
        clear_check();
        do_read(4'd7, 0);
`else
        tick();
`endif

        do_write(4'd3, 8'h5A);
        do_read(4'd3, 0);
        do_read(4'd3, 5);
        do_write(4'd15, 8'h11);
        do_write(4'd0, 8'h22);
        do_read(4'd15, 1);
        do_read(4'd0, 2);

        // Request held valid across a read; the follow-up write must issue once.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd3;
        wait_ready();
        tick();
        bus.req_write = 1'b1;
        bus.req_addr  = 4'd9;
        bus.req_wdata = 8'hC3;
        check("hold_ready_a1", bus.req_ready, 0);
        tick();
        check("hold_ready_a2", bus.req_ready, 0);
        tick();
        check("hold_ready_a3", bus.req_ready, 0);
        check("hold_rsp_data", bus.rsp_data, ref_mem[3]);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("hold_idle_ready", bus.req_ready, 1);
        check("hold_idle_rsp", bus.rsp_valid, 0);
        tick();
        bus.req_valid = 1'b0;
        check("hold_wr_we", bus.sram_we, 1);
        check("hold_wr_addr", bus.sram_addr, 9);
        ref_mem[9] = 8'hC3;
        ref_ok[9]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_once_we", bus.sram_we, 0);
            check("hold_once_busy", bus.busy, 0);
        end
        do_read(4'd9, 0);

        for (int n = 0; n < 80; n++) begin
            a = 4'($urandom);
            if (!ref_ok[a] || $urandom_range(0, 1) == 0)
                do_write(a, 8'($urandom));
            else
                do_read(a, int'($urandom_range(0, 4)));
        end

        // Reset asserted during the oe cycle of a read.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd0;
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
        check("mid_oe_before", bus.sram_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oe", bus.sram_oe, 0);
        check("mid_rst_rsp", bus.rsp_valid, 0);
        check("mid_rst_addr", bus.sram_addr, 0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
`ifdef SRAM_MASTER_CLEAR_EN
        clear_check();
`else
        check("mid_rel_ready", bus.req_ready, 1);
`endif
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_rsp", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b0;
        do_write(4'd5, 8'hA7);
        do_read(4'd5, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
